bus_responder: RTL and testbench

//  Memory-side responder for the CPU external bus. Ends every access the core's

---
 rtl/bus_pkg.sv | 15 +
 rtl/resp_wait_counter.sv | 32 +++
 rtl/bus_responder.sv | 136 +++++++++++++
 tb/tb_bus_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the external-bus responder.
package bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } state_e;

   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   localparam logic [7:0] ERR_READ_DATA = 8'hFF;

endpackage

// File: rtl/resp_wait_counter.sv
// Wait-state down-counter: loads a start value, steps down to zero and holds.
module resp_wait_counter (
   input  logic       CLK,
   input  logic       RST,
   input  logic       load_i,
   input  logic       dec_i,
   input  logic [3:0] val_i,
   output logic       zero_o
);

   logic [3:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = val_i;
      end else if (dec_i && (cnt_q != 4'd0)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= 4'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/bus_responder.sv
// Memory-side bus responder: latch request, wait states, one-cycle RDY.
// Optional RESP_WRITE_PROTECT_EN rejects writes at window offsets >= WP_BASE.
module bus_responder
   import bus_pkg::*;
#(
   parameter logic [15:0] MEM_BASE    = 16'h0000,
   parameter int          MEM_AW      = 12,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [11:0] WP_BASE     = 12'hF00
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ,
   input  logic        RW,
   input  logic [15:0] ADDR,
   input  logic [7:0]  DATA_IN,
   output logic [7:0]  DATA_OUT,
   output logic        RDY,
   output logic        BUS_ERR
);

   localparam logic [3:0] WAIT_LD =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam logic [16:0] WIN_SIZE = 17'(2 ** MEM_AW);

   state_e state_q, state_d;

   logic              cnt_load, cnt_dec, cnt_zero;
   logic [16:0]       off_live;
   logic              err_live;
   logic [MEM_AW-1:0] idx_q, cur_idx;
   logic              rw_q, cur_rw;
   logic              err_q, cur_err;
   logic [7:0]        wdata_q;
   logic [7:0]        dout_q;
   logic              enter_ack;

   logic [7:0] mem [2**MEM_AW];

   // 17-bit offset: an address below MEM_BASE wraps high and misses.
   assign off_live = {1'b0, ADDR} - {1'b0, MEM_BASE};

`ifdef RESP_WRITE_PROTECT_EN
   assign err_live = (off_live >= WIN_SIZE) ||
                     ((RW == RW_WRITE) &&
                      (off_live >= {5'd0, WP_BASE}));
`else
   logic unused_wp;
   assign unused_wp = ^WP_BASE;
   assign err_live  = (off_live >= WIN_SIZE);
`endif

   resp_wait_counter u_wait (
      .CLK    (CLK),
      .RST    (RST),
      .load_i (cnt_load),
      .dec_i  (cnt_dec),
      .val_i  (WAIT_LD),
      .zero_o (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      RDY      = 1'b0;
      BUS_ERR  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (REQ) begin
               cnt_load = 1'b1;
               state_d  = (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               state_d = ST_ACK;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_ACK: begin
            RDY     = 1'b1;
            BUS_ERR = err_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         idx_q   <= '0;
         rw_q    <= RW_READ;
         err_q   <= 1'b0;
         wdata_q <= 8'h00;
      end else if ((state_q == ST_IDLE) && REQ) begin
         idx_q   <= off_live[MEM_AW-1:0];
         rw_q    <= RW;
         err_q   <= err_live;
         wdata_q <= DATA_IN;
      end
   end

   // With zero wait states ACK follows IDLE directly, so use live inputs.
   assign cur_idx = (state_q == ST_IDLE) ? off_live[MEM_AW-1:0] : idx_q;
   assign cur_rw  = (state_q == ST_IDLE) ? RW : rw_q;
   assign cur_err = (state_q == ST_IDLE) ? err_live : err_q;

   assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dout_q <= 8'h00;
      end else if (enter_ack && (cur_rw == RW_READ)) begin
         dout_q <= cur_err ? ERR_READ_DATA : mem[cur_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if ((state_q == ST_ACK) && (rw_q == RW_WRITE) && !err_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign DATA_OUT = dout_q;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench for bus_responder: vector table, corner sequences, random ops.
module tb_bus_responder;

   localparam logic [15:0] MB  = 16'h0000;
   localparam int          AW  = 12;
   localparam int          WC  = 1;
   localparam logic [11:0] WPB = 12'hF00;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        REQ = 1'b0;
   logic        RW  = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic [7:0]  DATA_IN = 8'h00;
   logic [7:0]  DATA_OUT;
   logic        RDY;
   logic        BUS_ERR;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem_m [int];
   logic [7:0] dout_m;
   bit         dout_known;

   typedef struct {
      bit          rd;
      logic [15:0] a;
      logic [7:0]  d;
      bit          err;
      logic [7:0]  q;
   } vec_t;

   vec_t tbl [10];

   bus_responder #(
      .MEM_BASE    (MB),
      .MEM_AW      (AW),
      .WAIT_CYCLES (WC),
      .WP_BASE     (WPB)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .REQ      (REQ),
      .RW       (RW),
      .ADDR     (ADDR),
      .DATA_IN  (DATA_IN),
      .DATA_OUT (DATA_OUT),
      .RDY      (RDY),
      .BUS_ERR  (BUS_ERR)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One bus cycle; inputs are scrambled after the request edge.
   task automatic access(input bit rd, input logic [15:0] a,
                         input logic [7:0] d, output bit e,
                         output logic [7:0] q, output int lat,
                         output bit tmo);
      @(negedge CLK);
      REQ = 1'b1; RW = rd; ADDR = a; DATA_IN = d;
      @(posedge CLK);
      #1;
      REQ = 1'b0;
      ADDR = 16'($urandom);
      DATA_IN = 8'($urandom);
      RW = 1'($urandom);
      lat = 1; tmo = 1'b0; e = 1'b0; q = 8'h00;
      forever begin
         @(negedge CLK);
         if (RDY === 1'b1) break;
         if (lat >= 20) begin
            tmo = 1'b1;
            break;
         end
         @(posedge CLK);
         lat++;
      end
      e = BUS_ERR;
      q = DATA_OUT;
      @(negedge CLK);
      check("rdy_one_cycle", {31'd0, RDY}, 32'd0);
   endtask

   // Access checked against the reference model, which it then updates.
   task automatic op(input bit rd, input logic [15:0] a,
                     input logic [7:0] d, output bit e,
                     output logic [7:0] q);
      int off, lat;
      bit in_win, exp_err, tmo;
      off = int'(a) - int'(MB);
      in_win = (off >= 0) && (off < (1 << AW));
      exp_err = !in_win;
`ifdef RESP_WRITE_PROTECT_EN
      if (!rd && in_win && off >= int'(WPB)) exp_err = 1'b1;
`endif
      if (rd) begin
         if (exp_err) begin
            dout_m = 8'hFF; dout_known = 1'b1;
         end else if (mem_m.exists(off)) begin
            dout_m = mem_m[off]; dout_known = 1'b1;
         end else begin
            dout_known = 1'b0;
         end
      end else if (!exp_err) begin
         mem_m[off] = d;
      end
      access(rd, a, d, e, q, lat, tmo);
      check("timeout", {31'd0, tmo}, 32'd0);
      check("latency", lat, WC + 1);
      check("bus_err", {31'd0, e}, {31'd0, exp_err});
      if (dout_known) check("data_out", {24'd0, q}, {24'd0, dout_m});
   endtask

   initial begin : main
      bit e;
      logic [7:0] q, v;
      int t_prev, t;

      tbl[0] = '{1'b0, 16'h0010, 8'hA5, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 16'h0010, 8'h00, 1'b0, 8'hA5};
      tbl[2] = '{1'b1, 16'h2000, 8'h00, 1'b1, 8'hFF};
      tbl[3] = '{1'b0, 16'h0000, 8'h5A, 1'b0, 8'hFF};
      tbl[4] = '{1'b0, 16'h2000, 8'h11, 1'b1, 8'hFF};
      tbl[5] = '{1'b1, 16'h0000, 8'h00, 1'b0, 8'h5A};
      tbl[6] = '{1'b1, 16'h1000, 8'h00, 1'b1, 8'hFF};
      tbl[7] = '{1'b0, 16'h0EFF, 8'h3C, 1'b0, 8'hFF};
      tbl[8] = '{1'b1, 16'h0EFF, 8'h00, 1'b0, 8'h3C};
      tbl[9] = '{1'b1, 16'hFFFF, 8'h00, 1'b1, 8'hFF};

      RST = 1'b1; REQ = 1'b1; RW = 1'b1; ADDR = 16'h0010;
      repeat (4) begin
         @(negedge CLK);
         check("reset_rdy", {31'd0, RDY}, 32'd0);
         check("reset_err", {31'd0, BUS_ERR}, 32'd0);
         check("reset_dout", {24'd0, DATA_OUT}, 32'd0);
      end
      REQ = 1'b0;
      RST = 1'b0;
      dout_m = 8'h00; dout_known = 1'b1;

      for (int i = 0; i < 10; i++) begin
         op(tbl[i].rd, tbl[i].a, tbl[i].d, e, q);
         check($sformatf("tbl%0d_err", i), {31'd0, e}, {31'd0, tbl[i].err});
         check($sformatf("tbl%0d_q", i), {24'd0, q}, {24'd0, tbl[i].q});
      end

      // REQ held high: a read completes every WC+2 cycles.
      @(negedge CLK);
      REQ = 1'b1; RW = 1'b1; ADDR = 16'h0010;
      t_prev = -1;
      for (int c = 0; c < 16; c++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (RDY === 1'b1) begin
            check("b2b_dout", {24'd0, DATA_OUT}, 32'hA5);
            if (t_prev >= 0) check("b2b_period", c - t_prev, WC + 2);
            t_prev = c;
         end
      end
      REQ = 1'b0;
      repeat (6) @(negedge CLK);
      check("b2b_seen", {31'd0, t_prev >= 0}, 32'd1);
      dout_m = 8'hA5; dout_known = 1'b1;

      // Reset during WAIT of a write abandons it.
      op(1'b0, 16'h0020, 8'h11, e, q);
      @(negedge CLK);
      REQ = 1'b1; RW = 1'b0; ADDR = 16'h0020; DATA_IN = 8'h3C;
      @(posedge CLK);
      #1;
      REQ = 1'b0;
      RST = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         check("midrst_rdy", {31'd0, RDY}, 32'd0);
      end
      RST = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         check("postrst_rdy", {31'd0, RDY}, 32'd0);
      end
      check("postrst_dout", {24'd0, DATA_OUT}, 32'd0);
      dout_m = 8'h00; dout_known = 1'b1;
      op(1'b1, 16'h0020, 8'h00, e, q);
      check("midrst_old", {24'd0, q}, 32'h11);

      // Write-protect boundary.
`ifdef RESP_WRITE_PROTECT_EN
      op(1'b1, 16'h0F00, 8'h00, e, q);
      v = q;
      op(1'b0, 16'h0F00, 8'h77, e, q);
      check("wp_err", {31'd0, e}, 32'd1);
      op(1'b1, 16'h0F00, 8'h00, e, q);
      check("wp_read_old", {24'd0, q}, {24'd0, v});
      op(1'b0, 16'h0EFF, 8'h66, e, q);
      check("wp_below_err", {31'd0, e}, 32'd0);
`else
      op(1'b0, 16'h0F00, 8'h77, e, q);
      check("wp_err", {31'd0, e}, 32'd0);
      op(1'b1, 16'h0F00, 8'h00, e, q);
      check("wp_read_new", {24'd0, q}, 32'h77);
      v = q;
`endif

      for (int n = 0; n < 150; n++) begin
         logic [15:0] a;
         int k;
         k = $urandom_range(0, 9);
         if (k < 6) a = 16'($urandom_range(0, 63));
         else if (k < 8) a = 16'($urandom_range(16'h1000, 16'hFFFF));
         else a = 16'h0F00 + 16'($urandom_range(0, 255));
         op(1'($urandom), a, 8'($urandom), e, q);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
